// File: rtl/alu_datapath.sv
`default_nettype none
// ============================================================================
// Module   : alu_datapath
// Purpose  : Execute-stage datapath for the 16-bit-instruction / 8-bit-data
//            RISC core. It contains the operand-A select mux, a registered
//            8-bit ALU with a branch compare flag, the branch-qualify AND
//            gate, the write-back mux and the PC-increment mux.
// Ports    : clk, rst        - clock; synchronous active-high reset
//            opcode          - ALU operation (4 bits)
//            read_data1/2    - register-file read ports
//            immediate       - decoded immediate / branch offset
//            ALU_src         - operand B select (1: immediate)
//            load            - load instruction (A = immediate, WB = memory)
//            branch          - branch instruction active
//            mem_read_data   - data-memory read data
//            alu_result      - registered ALU result / memory address
//            compare         - registered branch-condition flag
//            branch_taken    - branch & compare
//            write_data      - register-file write-back value
//            pc_increment    - PC step value
// Config   : ALU_SHIFT_EN - when defined, opcodes 6/7 are SLL/SRL; when
//            undefined, the shifter is omitted and both opcodes give 8'h00.
// Revision : 1.0 - initial release
// ============================================================================
module alu_datapath (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] opcode,
  input  logic [7:0] read_data1,
  input  logic [7:0] read_data2,
  input  logic [7:0] immediate,
  input  logic       ALU_src,
  input  logic       load,
  input  logic       branch,
  input  logic [7:0] mem_read_data,
  output logic [7:0] alu_result,
  output logic       compare,
  output logic       branch_taken,
  output logic [7:0] write_data,
  output logic [7:0] pc_increment
);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_NOT   = 4'd5;
  localparam logic [3:0] OP_SLL   = 4'd6;
  localparam logic [3:0] OP_SRL   = 4'd7;
  localparam logic [3:0] OP_LOAD  = 4'd8;
  localparam logic [3:0] OP_STORE = 4'd9;
  localparam logic [3:0] OP_BEQ   = 4'd10;
  localparam logic [3:0] OP_BNE   = 4'd11;
  localparam logic [3:0] OP_BLT   = 4'd12;
  localparam logic [3:0] OP_MOV   = 4'd14;

  logic [7:0] w_op_a;
  logic [7:0] w_op_b;
  logic [7:0] w_sum;
  logic [7:0] w_diff;
  logic [7:0] alu_result_d, alu_result_q;
  logic       compare_d, compare_q;

  // Loads form their address from the immediate base, so A is redirected.
  assign w_op_a = load    ? immediate : read_data1;
  assign w_op_b = ALU_src ? immediate : read_data2;
  assign w_sum  = w_op_a + w_op_b;
  assign w_diff = w_op_a - w_op_b;

  always_comb begin
    alu_result_d = 8'h00;
    compare_d    = 1'b0;
    case (opcode)
      OP_ADD, OP_LOAD, OP_STORE: alu_result_d = w_sum;
      OP_SUB:   alu_result_d = w_diff;
      OP_AND:   alu_result_d = w_op_a & w_op_b;
      OP_OR:    alu_result_d = w_op_a | w_op_b;
      OP_XOR:   alu_result_d = w_op_a ^ w_op_b;
      OP_NOT:   alu_result_d = ~w_op_a;
`ifdef ALU_SHIFT_EN
      // Only the low three bits of B form the shift amount.
      OP_SLL:   alu_result_d = w_op_a << w_op_b[2:0];
      OP_SRL:   alu_result_d = w_op_a >> w_op_b[2:0];
`else
      OP_SLL, OP_SRL: alu_result_d = 8'h00;
`endif
      OP_BEQ: begin
        alu_result_d = w_diff;
        compare_d    = (w_op_a == w_op_b);
      end
      OP_BNE: begin
        alu_result_d = w_diff;
        compare_d    = (w_op_a != w_op_b);
      end
      OP_BLT: begin
        alu_result_d = w_diff;
        compare_d    = (w_op_a < w_op_b);
      end
      OP_MOV:   alu_result_d = w_op_b;
      default:  alu_result_d = 8'h00;  // JUMP, NOP
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_result_q <= 8'h00;
      compare_q    <= 1'b0;
    end else begin
      alu_result_q <= alu_result_d;
      compare_q    <= compare_d;
    end
  end

  assign alu_result   = alu_result_q;
  assign compare      = compare_q;
  // Registered flag qualified by the branch input of the current cycle.
  assign branch_taken = branch & compare_q;
  assign pc_increment = branch_taken ? immediate : 8'h01;
  assign write_data   = load ? mem_read_data : alu_result_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_datapath.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_datapath
// Purpose  : Directed self-checking bench for alu_datapath.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_datapath;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] opcode;
  logic [7:0] read_data1, read_data2, immediate, mem_read_data;
  logic       ALU_src, load, branch;
  logic [7:0] alu_result, write_data, pc_increment;
  logic       compare, branch_taken;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_datapath dut (
    .clk           (clk),
    .rst           (rst),
    .opcode        (opcode),
    .read_data1    (read_data1),
    .read_data2    (read_data2),
    .immediate     (immediate),
    .ALU_src       (ALU_src),
    .load          (load),
    .branch        (branch),
    .mem_read_data (mem_read_data),
    .alu_result    (alu_result),
    .compare       (compare),
    .branch_taken  (branch_taken),
    .write_data    (write_data),
    .pc_increment  (pc_increment)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with arbitrary inputs that would otherwise give a nonzero result.
    rst = 1'b1; opcode = 4'd0; read_data1 = 8'h5A; read_data2 = 8'h3C;
    immediate = 8'h77; ALU_src = 1'b0; load = 1'b1; branch = 1'b1;
    mem_read_data = 8'hC3;
    step();
    load = 1'b0; branch = 1'b0; #1;
    check("rst_result",  alu_result,   8'h00);
    check("rst_compare", {7'd0, compare}, 8'h00);
    check("rst_taken",   {7'd0, branch_taken}, 8'h00);
    check("rst_pcinc",   pc_increment, 8'h01);
    check("rst_wdata",   write_data,   8'h00);
    rst = 1'b0;

    // ADD with wrap
    opcode = 4'd0; read_data1 = 8'hFF; read_data2 = 8'h01; ALU_src = 1'b0;
    step();
    check("add_wrap", alu_result, 8'h00);
    read_data1 = 8'h7F;
    step();
    check("add_7f", alu_result, 8'h80);
    check("add_wdata", write_data, 8'h80);

    // SUB with immediate operand
    opcode = 4'd1; read_data1 = 8'h05; immediate = 8'h07; ALU_src = 1'b1;
    step();
    check("sub_imm", alu_result, 8'hFE);
    check("sub_cmp", {7'd0, compare}, 8'h00);

    // BEQ equal, then not equal
    opcode = 4'd10; read_data1 = 8'h33; read_data2 = 8'h33; immediate = 8'h04;
    ALU_src = 1'b0;
    step();
    check("beq_cmp", {7'd0, compare}, 8'h01);
    check("beq_res", alu_result, 8'h00);
    branch = 1'b1; #1;
    check("beq_taken", {7'd0, branch_taken}, 8'h01);
    check("beq_pcinc", pc_increment, 8'h04);
    branch = 1'b0; #1;
    check("beq_nobr_pcinc", pc_increment, 8'h01);
    read_data2 = 8'h34; branch = 1'b1;
    step();
    check("beq_ne_cmp", {7'd0, compare}, 8'h00);
    check("beq_ne_pcinc", pc_increment, 8'h01);
    check("beq_ne_res", alu_result, 8'hFF);

    // BNE with 33 vs 34
    opcode = 4'd11;
    step();
    check("bne_cmp", {7'd0, compare}, 8'h01);
    check("bne_taken", {7'd0, branch_taken}, 8'h01);
    branch = 1'b0;

    // BLT both ways
    opcode = 4'd12; read_data1 = 8'h03; read_data2 = 8'h05;
    step();
    check("blt_lt_cmp", {7'd0, compare}, 8'h01);
    read_data1 = 8'h05; read_data2 = 8'h03;
    step();
    check("blt_ge_cmp", {7'd0, compare}, 8'h00);
    check("blt_ge_res", alu_result, 8'h02);
    read_data1 = 8'h05; read_data2 = 8'h05;
    step();
    check("blt_eq_cmp", {7'd0, compare}, 8'h00);

    // Load path
    opcode = 4'd8; load = 1'b1; immediate = 8'h10; read_data2 = 8'h02;
    read_data1 = 8'hEE; mem_read_data = 8'hA5; ALU_src = 1'b0;
    step();
    check("load_addr", alu_result, 8'h12);
    check("load_wdata", write_data, 8'hA5);
    load = 1'b0; #1;
    check("noload_wdata", write_data, 8'h12);

    // Logic ops, NOT, MOV, JUMP
    read_data1 = 8'hF0; read_data2 = 8'h3C;
    opcode = 4'd2; step(); check("and", alu_result, 8'h30);
    opcode = 4'd3; step(); check("or",  alu_result, 8'hFC);
    opcode = 4'd4; step(); check("xor", alu_result, 8'hCC);
    opcode = 4'd5; step(); check("not", alu_result, 8'h0F);
    opcode = 4'd14; ALU_src = 1'b1; immediate = 8'h6B;
    step(); check("mov", alu_result, 8'h6B);
    opcode = 4'd13; step(); check("jump", alu_result, 8'h00);
    opcode = 4'd9; step(); check("store", alu_result, 8'h5B);
    ALU_src = 1'b0;

    // Shifts (B[7:3] ignored)
    opcode = 4'd6; read_data1 = 8'h81; read_data2 = 8'h01;
    step();
`ifdef ALU_SHIFT_EN
    check("sll", alu_result, 8'h02);
`else
    check("sll_off", alu_result, 8'h00);
`endif
    check("sll_cmp", {7'd0, compare}, 8'h00);
    opcode = 4'd7; read_data2 = 8'h09;
    step();
`ifdef ALU_SHIFT_EN
    check("srl", alu_result, 8'h40);
`else
    check("srl_off", alu_result, 8'h00);
`endif

    // Mid-operation reset discards the pending result
    opcode = 4'd0; read_data1 = 8'h11; read_data2 = 8'h22; rst = 1'b1;
    step();
    check("midrst_res", alu_result, 8'h00);
    rst = 1'b0;
    step();
    check("postrst_res", alu_result, 8'h33);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_datapath.md
# alu_datapath

Execute-stage datapath for the 16-bit-instruction / 8-bit-data RISC core. It combines four parts:
- operand-A select mux
- registered 8-bit ALU with branch compare flag
- branch-qualify AND gate
- write-back mux and PC-increment mux

It sits between the register file / instruction decoder and the data memory / program counter. The multicycle control unit drives its control inputs.

## Interface
Parameters:
- none (data width fixed at 8, opcode width fixed at 4)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- opcode  in  4  ALU operation from instruction decoder
- read_data1  in  8  register-file port 1
- read_data2  in  8  register-file port 2
- immediate  in  8  decoded immediate / branch offset
- ALU_src  in  1  1: operand B = immediate; 0: operand B = read_data2
- load  in  1  1: operand A = immediate, write-back = mem_read_data
- branch  in  1  branch instruction active (control unit)
- mem_read_data  in  8  data-memory read data
- alu_result  out  8  registered ALU result (also data-memory address)
- compare  out  1  registered branch-condition flag
- branch_taken  out  1  branch AND compare
- write_data  out  8  register-file write-back value
- pc_increment  out  8  PC step value

## Operation
- Operand A = load ? immediate : read_data1.
- Operand B = ALU_src ? immediate : read_data2.
- Opcode map; all arithmetic is modulo 256, unsigned, no carry-out:
  - 0 ADD A+B
  - 1 SUB A−B
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 NOT A
  - 6 SLL A by B[2:0]
  - 7 SRL A by B[2:0], zero fill
  - 8 LOAD address A+B
  - 9 STORE address A+B
  - 10 BEQ: result A−B, compare = (A==B)
  - 11 BNE: result A−B, compare = (A!=B)
  - 12 BLT: result A−B, compare = (A<B) unsigned
  - 13 JUMP: result 8'h00
  - 14 MOV: result B
  - 15 NOP: result 8'h00
- compare = 0 for every opcode except 10–12.
- branch_taken = branch & compare. Combinational; uses the registered compare and the current branch input.
- pc_increment = branch_taken ? immediate : 8'h01.
- write_data = load ? mem_read_data : alu_result. Combinational.
- No internal state machine. Sequencing belongs to the control unit.

## Timing
- alu_result and compare are registered. Both load on every rising clk edge with the value computed from the inputs present before that edge. Latency is 1 cycle.
- Reset: when rst=1 at a rising edge, alu_result ← 8'h00 and compare ← 0. The inputs are ignored on that edge.
- Values after reset, with branch=0 and load=0:
  - branch_taken = 0
  - pc_increment = 8'h01
  - write_data = 8'h00
- Reset asserted mid-operation discards the pending result. The first valid result appears one edge after rst deasserts.
- Mux and AND outputs follow their inputs within the same cycle. There is no handshake.
- Wrap-around examples: 8'hFF+8'h01 → 8'h00; 8'h00−8'h01 → 8'hFF.
- Shift amounts 0–7 only; B[7:3] is ignored.

## Configuration
- ALU_SHIFT_EN defined: opcodes 6 and 7 perform SLL/SRL as above.
- ALU_SHIFT_EN undefined: shifter logic is omitted; opcodes 6 and 7 produce result 8'h00 and compare 0.
- All other behaviour is identical in both builds.

## Test plan
- Reset: rst=1 for one edge with arbitrary inputs → alu_result=8'h00, compare=0, pc_increment=8'h01, write_data=8'h00.
- ADD wrap: opcode=0, read_data1=8'hFF, read_data2=8'h01, ALU_src=0 → after 1 edge alu_result=8'h00. Then read_data1=8'h7F → alu_result=8'h80.
- Immediate/SUB: opcode=1, read_data1=8'h05, immediate=8'h07, ALU_src=1 → alu_result=8'hFE, compare=0.
- Branch taken/not: opcode=10, read_data1=read_data2=8'h33, immediate=8'h04 → after edge compare=1; branch=1 gives branch_taken=1, pc_increment=8'h04; branch=0 gives pc_increment=8'h01. Then read_data2=8'h34 gives compare=0.
- Load path: load=1, opcode=8, immediate=8'h10, read_data2=8'h02, mem_read_data=8'hA5 → alu_result=8'h12, write_data=8'hA5. With load=0, write_data=alu_result.
- Shift config: opcode=6, read_data1=8'h81, read_data2=8'h01 → alu_result=8'h02 with ALU_SHIFT_EN, 8'h00 without.
